par_to_ser: RTL and testbench

PAR_TO_SER -- requirements
Module: par_to_ser

---
 rtl/par_to_ser_if.sv | 22 ++
 rtl/par_to_ser.sv | 116 +++++++++++
 tb/tb_par_to_ser.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/par_to_ser_if.sv
// Word-in / bit-out bundle for the parallel-to-serial converter.
// The slave modport is the serializer side and the master modport is the word source / bit sink.
interface par_to_ser_if #(
  parameter int WORD_SIZE = 8
);
  logic [WORD_SIZE-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;
  logic                 serial_out;
  logic                 lsb_out;
  logic                 busy;

  modport master (
    output data_in, data_valid,
    input  data_ready, serial_out, lsb_out, busy
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, serial_out, lsb_out, busy
  );
endinterface

// File: rtl/par_to_ser.sv
// MSB-first parallel-to-serial converter with a one-word hold buffer in front of the
// shift register and an optional run of idle cycles after each word's LSB.
module par_to_ser #(
  parameter int WORD_SIZE  = 8,
  parameter int GAP_CYCLES = 2
) (
  input logic         clk,
  input logic         reset,
  par_to_ser_if.slave bus
);
  localparam int BW = $clog2(WORD_SIZE);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_SIZE - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t               state, state_n;
  logic [WORD_SIZE-1:0] hold_reg, hold_reg_n;
  logic [WORD_SIZE-1:0] shift_reg, shift_reg_n;
  logic                 hold_full, hold_full_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [GW-1:0]        gap_cnt, gap_cnt_n;
  logic                 serial_q, serial_n;
  logic                 lsb_q, lsb_n;
  logic                 accept;
  logic                 load;

  assign bus.data_ready = ~hold_full;
  assign bus.busy       = (state != IDLE) | hold_full;
  assign bus.serial_out = serial_q;
  assign bus.lsb_out    = lsb_q;
  assign accept         = bus.data_valid & ~hold_full;

  // Next-state logic; serial_n/lsb_n are the values shown during the next cycle.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    gap_cnt_n   = gap_cnt;
    shift_reg_n = shift_reg;
    hold_reg_n  = hold_reg;
    hold_full_n = hold_full;
    serial_n    = 1'b0;
    lsb_n       = 1'b0;
    load        = 1'b0;

    unique case (state)
      IDLE: load = hold_full;
      SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
          if (GAP_CYCLES > 0) begin
            state_n   = GAP;
            gap_cnt_n = '0;
          end else if (hold_full) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          bit_cnt_n   = bit_cnt + 1'b1;
          serial_n    = shift_reg[WORD_SIZE-1];
          shift_reg_n = shift_reg << 1;
          lsb_n       = (bit_cnt_n == BIT_LAST);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (hold_full) load = 1'b1;
          else           state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // The MSB goes out straight from the hold register; the shift register keeps the rest.
    if (load) begin
      state_n     = SHIFT;
      bit_cnt_n   = '0;
      shift_reg_n = hold_reg << 1;
      serial_n    = hold_reg[WORD_SIZE-1];
      lsb_n       = 1'b0;
      hold_full_n = 1'b0;
    end

    // accept needs an empty hold and load a full one, so they never collide.
    if (accept) begin
      hold_full_n = 1'b1;
      hold_reg_n  = bus.data_in;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      serial_q  <= 1'b0;
      lsb_q     <= 1'b0;
    end else begin
      state     <= state_n;
      hold_reg  <= hold_reg_n;
      hold_full <= hold_full_n;
      shift_reg <= shift_reg_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      serial_q  <= serial_n;
      lsb_q     <= lsb_n;
    end
  end
endmodule

// File: tb/tb_par_to_ser.sv
// Scoreboard bench for par_to_ser: three instances (gaps 2, 0, 3) share one driver;
// a monitor deserializes the selected stream on each lsb_out pulse and checks it against the queue.
module tb_par_to_ser;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         dvalid;
  int           sel;

  logic rdy, ser, lsb, bsy;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         lsb_count = 0;
  int         last_lsb_cyc = -1;
  int         last_wait = 0;
  bit         stream_chk = 1'b0;
  logic [W-1:0] win = '0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  par_to_ser_if #(.WORD_SIZE(W)) bus2 ();
  par_to_ser_if #(.WORD_SIZE(W)) bus0 ();
  par_to_ser_if #(.WORD_SIZE(W)) bus3 ();

  assign bus2.data_in    = din;
  assign bus0.data_in    = din;
  assign bus3.data_in    = din;
  assign bus2.data_valid = dvalid && (sel == 0);
  assign bus0.data_valid = dvalid && (sel == 1);
  assign bus3.data_valid = dvalid && (sel == 2);

  par_to_ser #(.WORD_SIZE(W), .GAP_CYCLES(2)) dut_gap2 (.clk(clk), .reset(reset), .bus(bus2));
  par_to_ser #(.WORD_SIZE(W), .GAP_CYCLES(0)) dut_gap0 (.clk(clk), .reset(reset), .bus(bus0));
  par_to_ser #(.WORD_SIZE(W), .GAP_CYCLES(3)) dut_gap3 (.clk(clk), .reset(reset), .bus(bus3));

  always_comb begin
    rdy = bus2.data_ready;
    ser = bus2.serial_out;
    lsb = bus2.lsb_out;
    bsy = bus2.busy;
    if (sel == 1) begin
      rdy = bus0.data_ready;
      ser = bus0.serial_out;
      lsb = bus0.lsb_out;
      bsy = bus0.busy;
    end else if (sel == 2) begin
      rdy = bus3.data_ready;
      ser = bus3.serial_out;
      lsb = bus3.lsb_out;
      bsy = bus3.busy;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Offer one word at a negedge and hold it until the handshake edge has passed.
  task automatic applyStimulus(input logic [W-1:0] w, input bit expect_out);
    int n = 0;
    din    = w;
    dvalid = 1'b1;
    if (expect_out) exp_q.push_back(w);
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (!rdy) begin
      total++;
      bad++;
      $display("[TB] FAIL handshake_timeout: word %0h never accepted", w);
    end
    @(negedge clk);
    dvalid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (bsy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", {31'd0, bsy}, 32'd0);
  endtask

  // Monitor: the last W bits ending at an lsb_out cycle form one recovered word.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      win = '0;
    end else begin
      win = {win[W-2:0], ser};
      if (lsb) begin
        lsb_count++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word: got %0h, expected none", win);
        end else begin
          checkOutput("word", {24'd0, win}, {24'd0, exp_q.pop_front()});
        end
        if (stream_chk) begin
          if (last_lsb_cyc >= 0) checkOutput("stream_spacing", cyc - last_lsb_cyc, 32'd8);
          last_lsb_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] exp_bits;
    int           lsb_before;
    int           n;

    reset  = 1'b0;
    din    = '0;
    dvalid = 1'b0;
    sel    = 0;

    // Reset dominates an offered word.
    @(negedge clk);
    din    = 8'hA5;
    dvalid = 1'b1;
    #1;
    checkOutput("reset_serial", {31'd0, ser}, 32'd0);
    checkOutput("reset_lsb", {31'd0, lsb}, 32'd0);
    checkOutput("reset_busy", {31'd0, bsy}, 32'd0);
    checkOutput("reset_ready", {31'd0, rdy}, 32'd1);
    @(negedge clk);
    checkOutput("reset_no_transfer", {31'd0, bsy}, 32'd0);

    // Release with valid high: 0xA5 accepted at the first edge, MSB one cycle later.
    reset = 1'b1;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    checkOutput("accept_after_release", {31'd0, bsy}, 32'd1);
    checkOutput("ready_low_when_held", {31'd0, rdy}, 32'd0);
    checkOutput("serial_idle_before_load", {31'd0, ser}, 32'd0);
    dvalid   = 1'b0;
    exp_bits = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("a5_bit", {31'd0, ser}, {31'd0, exp_bits[7-i]});
      checkOutput("a5_lsb", {31'd0, lsb}, (i == 7) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("a5_gap_serial", {31'd0, ser}, 32'd0);
      checkOutput("a5_gap_busy", {31'd0, bsy}, 32'd1);
    end
    @(negedge clk);
    checkOutput("a5_busy_fall", {31'd0, bsy}, 32'd0);

    // Backpressure: 0x5A waits until 0x3C moves into the shift register.
    applyStimulus(8'hC3, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    checkOutput("ready_low_during_backpressure", {31'd0, rdy}, 32'd0);
    applyStimulus(8'h5A, 1'b1);
    checkOutput("backpressure_wait", last_wait, 32'd9);
    waitIdle();

    // Changing data_in without valid must not start anything.
    for (int i = 0; i < 3; i++) begin
      din = 8'hE0 + 8'(i);
      @(negedge clk);
    end
    checkOutput("no_valid_no_effect", {31'd0, bsy}, 32'd0);

    // Reset after four bits of 0xFF with 0x81 held.
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'h81, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ff_fourth_bit", {31'd0, ser}, 32'd1);
    lsb_before = lsb_count;
    #2 reset = 1'b0;
    #1;
    checkOutput("midword_reset_serial", {31'd0, ser}, 32'd0);
    checkOutput("midword_reset_lsb", {31'd0, lsb}, 32'd0);
    checkOutput("midword_reset_busy", {31'd0, bsy}, 32'd0);
    checkOutput("midword_reset_ready", {31'd0, rdy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("no_lsb_for_discarded", lsb_count, lsb_before);
    checkOutput("discarded_hold_empty", {31'd0, bsy}, 32'd0);
    applyStimulus(8'h42, 1'b1);
    waitIdle();

    // Zero-gap instance: continuous stream of 14 words.
    sel          = 1;
    stream_chk   = 1'b1;
    last_lsb_cyc = -1;
    lsb_before   = lsb_count;
    for (int k = 0; k < 14; k++) applyStimulus(8'(k * 19), 1'b1);
    waitIdle();
    stream_chk = 1'b0;
    checkOutput("stream_word_count", lsb_count - lsb_before, 32'd14);

    // Three-cycle gap between two queued words.
    sel = 2;
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'hB1, 1'b1);
    n = 0;
    while (!lsb && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("gap3_first_lsb", {31'd0, lsb}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("gap3_zero", {30'd0, ser, lsb}, 32'd0);
    end
    @(negedge clk);
    checkOutput("gap3_second_msb", {31'd0, ser}, 32'd1);
    waitIdle();

    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
